// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Grants are combinational; each read returns on the tagged port one cycle after its grant.
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_gnt_o,
  output logic              p0_rvalid_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_gnt_o,
  output logic              p1_rvalid_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  // ST_HOLD keeps grants off until the first clock edge after reset release.
  typedef enum logic {ST_HOLD, ST_RUN} state_t;

  state_t state_reg, state_next;
  logic   last_reg, last_next;          // 1 = port 1 was granted most recently
  logic   pend_reg, pend_next;
  logic   pend_tag_reg, pend_tag_next;

  logic [1:0]        req;
  logic [1:0]        we;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];
  logic [DATA_W-1:0] rdata [2];
  logic              sel;

  assign req      = {p1_req_i, p0_req_i};
  assign we       = {p1_we_i, p0_we_i};
  assign addr[0]  = p0_addr_i;
  assign addr[1]  = p1_addr_i;
  assign wdata[0] = p0_wdata_i;
  assign wdata[1] = p1_wdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_HOLD;
      last_reg     <= 1'b1;
      pend_reg     <= 1'b0;
      pend_tag_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      pend_reg     <= pend_next;
      pend_tag_reg <= pend_tag_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    pend_next     = 1'b0;
    pend_tag_next = pend_tag_reg;
    gnt           = 2'b00;
    sel           = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    mem_write_o   = 1'b0;
    mem_read_o    = 1'b0;

    case (state_reg)
      ST_HOLD: state_next = ST_RUN;
      ST_RUN: begin
        // Port 0 wins when alone or when port 1 had the previous grant.
        if (req[0] && (!req[1] || last_reg)) gnt[0] = 1'b1;
        else if (req[1])                     gnt[1] = 1'b1;
      end
      default: state_next = ST_HOLD;
    endcase

    if (|gnt) begin
      sel           = gnt[1];
      mem_addr_o    = addr[sel];
      mem_wdata_o   = wdata[sel];
      mem_write_o   = we[sel];
      mem_read_o    = ~we[sel];
      last_next     = sel;
      pend_next     = ~we[sel];
      pend_tag_next = sel;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign rvalid[gi] = pend_reg && (pend_tag_reg == 1'(gi));
    assign rdata[gi]  = rvalid[gi] ? mem_rdata_i : '0;
  end

  assign p0_gnt_o    = gnt[0];
  assign p1_gnt_o    = gnt[1];
  assign p0_rvalid_o = rvalid[0];
  assign p1_rvalid_o = rvalid[1];
  assign p0_rdata_o  = rdata[0];
  assign p1_rdata_o  = rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// round-robin / shadow-memory reference model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i;
  logic [15:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
  logic        p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
  logic [15:0] p0_rdata_o, p1_rdata_o;
  logic [15:0] mem_addr_o, mem_wdata_o;
  logic        mem_write_o, mem_read_o;
  logic [15:0] mem_rdata_i = '0;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
    .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
    .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_write_o(mem_write_o), .mem_read_o(mem_read_o), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int i);
    return (16'(i) * 16'h0101) ^ 16'h5A5A;
  endfunction

  // External memory: writes land on the edge, reads return registered data.
  logic [15:0] tb_mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_write_o) tb_mem[mem_addr_o[7:0]] = mem_wdata_o;
      if (mem_read_o)  mem_rdata_i <= tb_mem[mem_addr_o[7:0]];
    end
  end

  // Reference model state
  logic [15:0] shadow [0:255];
  int          last_port;
  bit          ret_v;
  int          ret_p;
  logic [15:0] ret_d;
  int          n_cmp = 0;
  int          n_err = 0;

  // Observations from the most recent step
  logic        s_gnt0, s_gnt1, s_mw, s_rv0, s_rv1;
  logic [15:0] s_addr, s_wd, s_rd0, s_rd1;
  int          s_win;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input int p, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin
      p0_req_i = r; p0_we_i = w; p0_addr_i = a; p0_wdata_i = d;
    end else begin
      p1_req_i = r; p1_we_i = w; p1_addr_i = a; p1_wdata_i = d;
    end
  endtask

  task automatic rand_cmd(input int p);
    logic r;
    r = ($urandom_range(0, 3) != 0);
    set_cmd(p, r, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, return just after the edge.
  task automatic step();
    int          win;
    logic [15:0] a, w;
    logic        wr;
    @(negedge clk);
    win = -1;
    if (p0_req_i && p1_req_i) win = (last_port == 1) ? 0 : 1;
    else if (p0_req_i)        win = 0;
    else if (p1_req_i)        win = 1;
    a = '0; w = '0; wr = 1'b0;
    if (win == 0) begin a = p0_addr_i; w = p0_wdata_i; wr = p0_we_i; end
    if (win == 1) begin a = p1_addr_i; w = p1_wdata_i; wr = p1_we_i; end
    s_gnt0 = p0_gnt_o; s_gnt1 = p1_gnt_o; s_mw = mem_write_o;
    s_addr = mem_addr_o; s_wd = mem_wdata_o;
    s_rv0 = p0_rvalid_o; s_rv1 = p1_rvalid_o; s_rd0 = p0_rdata_o; s_rd1 = p1_rdata_o;
    s_win = win;
    check_val("gnt0", p0_gnt_o, win == 0);
    check_val("gnt1", p1_gnt_o, win == 1);
    check_val("mem_write", mem_write_o, (win >= 0) && wr);
    check_val("mem_read", mem_read_o, (win >= 0) && !wr);
    check_val("mem_addr", mem_addr_o, a);
    check_val("mem_wdata", mem_wdata_o, w);
    check_val("rvalid0", p0_rvalid_o, ret_v && ret_p == 0);
    check_val("rvalid1", p1_rvalid_o, ret_v && ret_p == 1);
    check_val("rdata0", p0_rdata_o, (ret_v && ret_p == 0) ? ret_d : 16'h0);
    check_val("rdata1", p1_rdata_o, (ret_v && ret_p == 1) ? ret_d : 16'h0);
    ret_v = 1'b0;
    if (win >= 0) begin
      last_port = win;
      if (wr) shadow[a[7:0]] = w;
      else begin
        ret_v = 1'b1; ret_p = win; ret_d = shadow[a[7:0]];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    ret_v = 1'b0;
    last_port = 1;
    #1;
    check_val("rst_gnt", {p1_gnt_o, p0_gnt_o}, 0);
    check_val("rst_rvalid", {p1_rvalid_o, p0_rvalid_o}, 0);
    check_val("rst_rdata", {p1_rdata_o, p0_rdata_o}, 0);
    check_val("rst_mem_strobes", {mem_write_o, mem_read_o}, 0);
    check_val("rst_mem_addr", mem_addr_o, 0);
    check_val("rst_mem_wdata", mem_wdata_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("pre_edge_gnt", {p1_gnt_o, p0_gnt_o}, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    last_port = 1; ret_v = 1'b0; ret_p = 0; ret_d = '0; s_win = -1;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    set_cmd(0, 1'b1, 1'b0, 16'h0000, 16'h0);
    set_cmd(1, 1'b1, 1'b0, 16'h0004, 16'h0);
    apply_reset();

    // Lone write
    set_cmd(1, 1'b0, 1'b0, 16'h0, 16'h0);
    set_cmd(0, 1'b1, 1'b1, 16'h0004, 16'h1234);
    step();
    check_val("d34_gnt0", s_gnt0, 1);
    check_val("d34_mw", s_mw, 1);
    check_val("d34_addr", s_addr, 16'h0004);
    check_val("d34_wdata", s_wd, 16'h1234);

    // Read back the same address
    set_cmd(0, 1'b1, 1'b0, 16'h0004, 16'h0);
    step();
    check_val("d35_gnt0", s_gnt0, 1);
    set_cmd(0, 1'b0, 1'b0, 16'h0, 16'h0);
    step();
    check_val("d35_rv0", s_rv0, 1);
    check_val("d35_rd0", s_rd0, 16'h1234);
    check_val("d35_rv1", s_rv1, 0);

    // Write from p1, read from p0 on the very next cycle
    set_cmd(1, 1'b1, 1'b1, 16'h0008, 16'h9ABC);
    step();
    set_cmd(1, 1'b0, 1'b0, 16'h0, 16'h0);
    set_cmd(0, 1'b1, 1'b0, 16'h0008, 16'h0);
    step();
    set_cmd(0, 1'b0, 1'b0, 16'h0, 16'h0);
    step();
    check_val("d38_rv0", s_rv0, 1);
    check_val("d38_rd0", s_rd0, 16'h9ABC);

    set_cmd(0, 1'b1, 1'b1, 16'h0000, 16'hABCD);
    step();

    // Reset arrives the cycle after a read grant
    set_cmd(0, 1'b1, 1'b0, 16'h0002, 16'h0);
    step();
    set_cmd(0, 1'b1, 1'b0, 16'h0000, 16'h0);
    set_cmd(1, 1'b1, 1'b0, 16'h0004, 16'h0);
    apply_reset();

    // Contended reads right after reset
    step();
    check_val("d36_gnt0", s_gnt0, 1);
    check_val("d36_rv_after_rst", {s_rv1, s_rv0}, 0);
    set_cmd(0, 1'b0, 1'b0, 16'h0, 16'h0);
    step();
    check_val("d36_gnt1", s_gnt1, 1);
    check_val("d36_rd0", s_rd0, 16'hABCD);
    set_cmd(1, 1'b0, 1'b0, 16'h0, 16'h0);
    step();
    check_val("d36_rv1", s_rv1, 1);
    check_val("d36_rd1", s_rd1, 16'h1234);

    // Both hold requests: grants alternate
    set_cmd(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    set_cmd(1, 1'b1, 1'b0, 16'h0012, 16'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_val("d37_gnt0", s_gnt0, (i % 2) == 0);
      check_val("d37_gnt1", s_gnt1, (i % 2) == 1);
    end

    // Random traffic; a requester only changes its command once granted
    for (int c = 0; c < 400; c++) begin
      if (!p0_req_i || s_win == 0) rand_cmd(0);
      if (!p1_req_i || s_win == 1) rand_cmd(1);
      step();
    end
    set_cmd(0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_cmd(1, 1'b0, 1'b0, 16'h0, 16'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
